// File: rtl/ps2_keyboard.sv
// rtl/ps2_keyboard.sv - PS/2 set-2 keyboard receiver and Hack keyboard word decoder
// Purpose: receive PS/2 frames, validate them, and decode scan codes into the
//          Hack keyboard word that the CPU reads at address 0x6000.
// Ports:
//   clk        in   system clock; all logic runs in this domain
//   rst        in   synchronous reset, active-high
//   ps2_clk    in   PS/2 clock, asynchronous, idle high
//   ps2_data   in   PS/2 data, asynchronous, idle high
//   key_code   out  Hack key word, 0 when no key is held (bits 15:8 always 0)
//   key_valid  out  one-cycle pulse when key_code changes value
//   scan_code  out  last correctly received raw byte
//   scan_valid out  one-cycle pulse per correctly received byte
//   frame_err  out  one-cycle pulse on start, parity, stop or timeout error
`timescale 1ns/1ps
module ps2_keyboard #(
  parameter int CLK_HZ     = 50000000,
  parameter int TIMEOUT_US = 2000,
  parameter int FILTER_LEN = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [15:0] key_code,
  output logic        key_valid,
  output logic [7:0]  scan_code,
  output logic        scan_valid,
  output logic        frame_err
);
  localparam int TIMEOUT_CYC = CLK_HZ / 1000000 * TIMEOUT_US;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int FW = $clog2(FILTER_LEN + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [1:0]    clk_sync, data_sync;
  logic [FW-1:0] filt_cnt;
  logic          clk_filt, clk_filt_q;
  logic          strobe, data_bit;
  state_t        state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_ok;
  logic [TW-1:0] to_cnt;
  logic          ext, brk, shift;
  logic [7:0]    held_code;
  logic          held_ext;
  logic [7:0]    xlat;

  // Falling edge of the filtered clock is the only bit-sample strobe.
  assign strobe   = clk_filt_q & ~clk_filt;
  assign data_bit = data_sync[1];

  // Each case item packs {unshifted, shifted}; codes that ignore shift repeat the value.
  function automatic logic [7:0] translate(input logic e, input logic s, input logic [7:0] c);
    logic [15:0] pair;
    pair = 16'h0000;
    if (e) begin
      case (c)
        8'h6B: pair = {2{8'd130}};  8'h75: pair = {2{8'd131}};  8'h74: pair = {2{8'd132}};
        8'h72: pair = {2{8'd133}};  8'h6C: pair = {2{8'd134}};  8'h69: pair = {2{8'd135}};
        8'h7D: pair = {2{8'd136}};  8'h7A: pair = {2{8'd137}};  8'h70: pair = {2{8'd138}};
        8'h71: pair = {2{8'd139}};
        default: pair = 16'h0000;
      endcase
    end else begin
      case (c)
        8'h1C: pair = "aA"; 8'h32: pair = "bB"; 8'h21: pair = "cC"; 8'h23: pair = "dD";
        8'h24: pair = "eE"; 8'h2B: pair = "fF"; 8'h34: pair = "gG"; 8'h33: pair = "hH";
        8'h43: pair = "iI"; 8'h3B: pair = "jJ"; 8'h42: pair = "kK"; 8'h4B: pair = "lL";
        8'h3A: pair = "mM"; 8'h31: pair = "nN"; 8'h44: pair = "oO"; 8'h4D: pair = "pP";
        8'h15: pair = "qQ"; 8'h2D: pair = "rR"; 8'h1B: pair = "sS"; 8'h2C: pair = "tT";
        8'h3C: pair = "uU"; 8'h2A: pair = "vV"; 8'h1D: pair = "wW"; 8'h22: pair = "xX";
        8'h35: pair = "yY"; 8'h1A: pair = "zZ";
        8'h16: pair = "1!"; 8'h1E: pair = "2@"; 8'h26: pair = "3#"; 8'h25: pair = "4$";
        8'h2E: pair = "5%"; 8'h36: pair = "6^"; 8'h3D: pair = "7&"; 8'h3E: pair = "8*";
        8'h46: pair = "9("; 8'h45: pair = "0)";
        8'h0E: pair = "`~"; 8'h4E: pair = "-_"; 8'h55: pair = "=+"; 8'h54: pair = "[{";
        8'h5B: pair = "]}"; 8'h5D: pair = {8'd92, "|"}; 8'h4C: pair = ";:"; 8'h52: pair = {"'", 8'd34};
        8'h41: pair = ",<"; 8'h49: pair = ".>"; 8'h4A: pair = "/?";
        8'h29: pair = {2{8'd32}};   8'h5A: pair = {2{8'd128}};  8'h66: pair = {2{8'd129}};
        8'h76: pair = {2{8'd140}};
        8'h05: pair = {2{8'd141}};  8'h06: pair = {2{8'd142}};  8'h04: pair = {2{8'd143}};
        8'h0C: pair = {2{8'd144}};  8'h03: pair = {2{8'd145}};  8'h0B: pair = {2{8'd146}};
        8'h83: pair = {2{8'd147}};  8'h0A: pair = {2{8'd148}};  8'h01: pair = {2{8'd149}};
        8'h09: pair = {2{8'd150}};  8'h78: pair = {2{8'd151}};  8'h07: pair = {2{8'd152}};
        default: pair = 16'h0000;
      endcase
    end
    return s ? pair[7:0] : pair[15:8];
  endfunction

  assign xlat = translate(ext, shift, scan_code);

  // Synchronizers and glitch filter on the PS/2 clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync   <= 2'b11;
      data_sync  <= 2'b11;
      filt_cnt   <= '0;
      clk_filt   <= 1'b1;
      clk_filt_q <= 1'b1;
    end else begin
      clk_sync   <= {clk_sync[0], ps2_clk};
      data_sync  <= {data_sync[0], ps2_data};
      clk_filt_q <= clk_filt;
      if (clk_sync[1] == clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        clk_filt <= clk_sync[1];
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + FW'(1);
      end
    end
  end

  // Frame receiver: start, 8 data bits LSB first, odd parity, stop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= 3'd0;
      shreg      <= 8'h00;
      par_ok     <= 1'b0;
      to_cnt     <= '0;
      scan_code  <= 8'h00;
      scan_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      scan_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (state == IDLE || strobe) to_cnt <= '0;
      else                         to_cnt <= to_cnt + TW'(1);

      if (state != IDLE && !strobe && to_cnt == TW'(TIMEOUT_CYC - 1)) begin
        frame_err <= 1'b1;
        state     <= IDLE;
      end else if (strobe) begin
        case (state)
          IDLE: begin
            if (!data_bit) begin
              state   <= DATA;
              bit_cnt <= 3'd0;
            end else begin
              frame_err <= 1'b1;
            end
          end
          DATA: begin
            shreg   <= {data_bit, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par_ok <= ^{shreg, data_bit};
            state  <= STOP;
          end
          STOP: begin
            if (data_bit && par_ok) begin
              scan_code  <= shreg;
              scan_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Scan-code decoder: prefix flags, shift tracking, last-pressed key wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_code  <= 16'h0000;
      key_valid <= 1'b0;
      ext       <= 1'b0;
      brk       <= 1'b0;
      shift     <= 1'b0;
      held_code <= 8'h00;
      held_ext  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (scan_valid) begin
        if (scan_code == 8'hE0) begin
          ext <= 1'b1;
        end else if (scan_code == 8'hF0) begin
          brk <= 1'b1;
        end else begin
          ext <= 1'b0;
          brk <= 1'b0;
          if (!ext && (scan_code == 8'h12 || scan_code == 8'h59)) begin
            shift <= ~brk;
          end else if (brk) begin
            // Only releasing the held key clears the word.
            if (scan_code == held_code && ext == held_ext && key_code != 16'h0000) begin
              key_code  <= 16'h0000;
              key_valid <= 1'b1;
            end
          end else if (xlat != 8'h00) begin
            key_code  <= {8'h00, xlat};
            key_valid <= ({8'h00, xlat} != key_code);
            held_code <= scan_code;
            held_ext  <= ext;
          end
        end
      end
    end
  end
endmodule

// File: doc/ps2_keyboard.md
Name: ps2_keyboard

Overview:
- Input-side counterpart to the VGA text output path: receives PS/2 set-2 scan codes from the keyboard connector and decodes them into the Hack keyboard word.
- The CPU reads that word at the memory-mapped keyboard address (0x6000).
- Holds the code of the currently pressed key; 0 when no key is held.
- Runs entirely in the CPU clock domain; PS/2 lines are asynchronous inputs.

Parameters:
- CLK_HZ, 50000000, system clock frequency; used only to derive the frame timeout.
- TIMEOUT_US, 2000, maximum gap between PS/2 falling edges inside one frame before abort.
- FILTER_LEN, 8, consecutive identical synchronized samples required before ps2_clk changes its filtered level.

Ports:
- clk  in  1  system clock (50 MHz).
- rst  in  1  synchronous reset, active-high.
- ps2_clk  in  1  PS/2 clock from keyboard, asynchronous, idle high.
- ps2_data  in  1  PS/2 data from keyboard, asynchronous, idle high.
- key_code  out  16  Hack keyboard word; bits 15:8 always 0.
- key_valid  out  1  one-cycle pulse whenever key_code changes value.
- scan_code  out  8  last correctly received raw byte (debug).
- scan_valid  out  1  one-cycle pulse per correctly received byte.
- frame_err  out  1  one-cycle pulse on parity, start, stop or timeout error.

Behaviour:
- Reset: all outputs 0; receive FSM to IDLE; ext, brk and shift flags cleared. Reset mid-frame discards the partial byte with no frame_err.
- Input conditioning: 2-FF synchronizers on both lines. ps2_clk filtered level toggles only after FILTER_LEN equal samples. A falling edge of the filtered clock is the sample strobe, and ps2_data (synchronized) is sampled on that strobe.
- Receive FSM:
  - IDLE: on strobe, data=0 -> DATA with bit counter 0; data=1 -> frame_err pulse, stay in IDLE.
  - DATA: 8 strobes, LSB first, into a shift register; after the 8th strobe -> PARITY.
  - PARITY: on strobe, check odd parity over 8 data bits plus parity bit; record pass/fail -> STOP.
  - STOP: on strobe, stop=1 and parity ok -> scan_code<=byte, scan_valid=1 on the next clk. Otherwise frame_err=1. Either way -> IDLE.
  - Timeout: a counter clears on each strobe. In any state other than IDLE, reaching CLK_HZ/1000000*TIMEOUT_US cycles -> frame_err pulse, -> IDLE, byte discarded.
- Decoder acts on the scan_valid cycle; key_code/key_valid update one clk later (two clk after the stop strobe).
  - 0xE0: set ext.
  - 0xF0: set brk.
  - Any other byte is a key event with ext/brk qualifiers; after processing, ext and brk clear.
  - Shift (0x12 or 0x59, ext=0): make sets shift, break clears it; key_code untouched.
  - Make of a mapped key: key_code <= translated code; also remember held scancode+ext.
  - Break: if byte+ext equal the held key -> key_code <= 0. Otherwise no change.
  - Unmapped bytes, and 0xAA/0xFA/0xEE/0xFE: no key_code change.
  - Typematic repeat of the same make: key_code rewritten with the same value, no key_valid.
  - A new make while another key is held: the new key replaces the old one (last-pressed wins).
- Translation (Hack codes):
  - Letters: shift=0 lower-case ASCII; shift=1 upper-case ASCII.
  - Digits and US punctuation: shifted variants per US layout.
  - Space 0x29 -> 32.
  - Enter 0x5A -> 128; Backspace 0x66 -> 129; Esc 0x76 -> 140.
  - With ext=1: Left E0 6B -> 130, Up E0 75 -> 131, Right E0 74 -> 132, Down E0 72 -> 133, Home E0 6C -> 134, End E0 69 -> 135, PgUp E0 7D -> 136, PgDn E0 7A -> 137, Ins E0 70 -> 138, Del E0 71 -> 139.
  - F1..F12 -> 141..152.
  - Translation is combinational ROM logic, not a block RAM.
- Boundary cases:
  - A byte completing in the same cycle as rst: reset wins.
  - A frame error between E0/F0 and its key byte leaves the flags set; the next good byte consumes them.

Test Plan:
- Send frame 0x1C (good parity) -> scan_valid with scan_code=0x1C; key_code=0x0061 two clk after the stop strobe; one key_valid pulse.
- Send 12, 1C, F0 1C, F0 12 -> key_code goes 0x0041 then 0x0000; shift flag clear at end; exactly 2 key_valid pulses.
- Send E0 75 then E0 F0 75 -> key_code=131 (0x0083), then 0; no frame_err.
- Send 0x1C with the parity bit flipped -> frame_err pulse; no scan_valid; key_code unchanged at its prior value.
- Send start bit plus 4 data bits, then hold ps2_clk high beyond TIMEOUT_US -> frame_err pulse, FSM in IDLE; following good frame 0x29 -> key_code=32.
- Assert rst for 1 cycle after 5 data bits of a frame -> all outputs 0, no frame_err; next clean frame 0x5A -> key_code=128.
